local_bus_arbiter: RTL and testbench
====================================

Name: local_bus_arbiter

Overview:
- Shares the single Local Bus between two command masters, M0 and M1. Typical pairing: the SPI command parser and a UART command parser.
- Accepts one request per master and arbitrates round-robin.
- Drives one bus transaction at a time: one-cycle CS pulse, write data or read.
- For reads, collects i_Bus_Rd_DV/data from the addressed chip-select, or times out with 16'hDEAD, then acks the owning master.

Parameters:
ADDR8_PER_CS, 65536, byte addresses per chip-select; AW = $clog2(ADDR8_PER_CS).
WD_LIMIT, 8, cycles to wait for read DV after the CS pulse before timeout (legal 2..255).

Ports:
i_Bus_Clk  input  1  bus clock; all logic on posedge
i_Rst  input  1  asynchronous active-high reset
i_M0_Req / i_M1_Req  input  1  transaction request; level, held until Ack
i_M0_Wr_Rd_n / i_M1_Wr_Rd_n  input  1  1=write, 0=read
i_M0_CS_Index / i_M1_CS_Index  input  2  target chip-select 0..3
i_M0_Addr8 / i_M1_Addr8  input  AW  byte address
i_M0_Wr_Data / i_M1_Wr_Data  input  16  write data
o_M0_Ack / o_M1_Ack  output  1  one-cycle completion pulse
o_M0_Rd_Data / o_M1_Rd_Data  output  16  read data; valid with Ack, held until next Ack to that master
o_M0_Timeout / o_M1_Timeout  output  1  pulses with Ack when a read timed out
o_Bus_CS_Array  output  4  one-hot CS pulse, one cycle per transaction
o_Bus_Wr_Rd_n  output  1  bus direction
o_Bus_Addr8  output  AW  bus address
o_Bus_Wr_Data  output  16  bus write data
i_Bus_Rd_Data_CS0..CS3  input  16 each  read data per chip-select
i_Bus_Rd_DV_Array  input  4  read data valid per chip-select

Behaviour:
- Reset (async, any time including mid-transaction):
  - state IDLE; every output 0; r_Last_Grant=1 so M0 wins the first tie; watchdog cleared.
  - A transaction in flight is abandoned with no Ack.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - If any Req is high, latch the winner's Wr_Rd_n/CS_Index/Addr8/Wr_Data into bus registers, record the owner, update r_Last_Grant, go to ISSUE.
  - Tie: grant the master not granted last.
  - Single requester: grant it regardless of history.
- ISSUE (1 cycle):
  - o_Bus_CS_Array[CS_Index]=1 for exactly this cycle.
  - Write -> DONE. Read -> clear watchdog, go to WAIT_RD.
- WAIT_RD:
  - i_Bus_Rd_DV_Array[CS_Index]=1: capture the matching CS data into the owner's Rd_Data, go to DONE.
  - DV on any other CS index is ignored.
  - Else watchdog counts; at count == WD_LIMIT-1: owner Rd_Data=16'hDEAD, set timeout flag, go to DONE.
  - DV and expiry in the same cycle: DV wins, no timeout.
- DONE (1 cycle):
  - Owner's Ack=1; owner's Timeout=1 if flagged.
  - Next state IDLE.
- Handshake:
  - Master holds Req and fields stable from assertion until it samples Ack.
  - Master deasserts Req on the edge it sees Ack.
  - Arbiter does not sample Req during the DONE->IDLE cycle, so no duplicate transaction occurs.
- Latencies:
  - Write: Req to CS pulse = 1 cycle; CS pulse to Ack = 1 cycle.
  - Read: Ack one cycle after DV, or WD_LIMIT+1 cycles after the CS pulse on timeout.
- Bus outputs (Addr, Wr_Data, Wr_Rd_n) hold their last values between transactions; only CS pulses.
- Req dropped by a master before Ack (protocol violation): the transaction still completes and Ack is still issued.

Optional Feature:
LOCAL_BUS_ARB_FIXED_PRIO_EN
- Defined: M0 always wins ties; r_Last_Grant is not used. Allows starvation of M1; intended for debug builds where the SPI master must pre-empt.
- Undefined: round-robin as above.

Decomposition:
- Package local_bus_pkg:
  - state encodings (IDLE/ISSUE/WAIT_RD/DONE)
  - NUM_CS=4
  - RD_TIMEOUT_DATA=16'hDEAD
  - CS index width
- Sub-module local_bus_rr_pick: combinational two-way round-robin pick from the two Req bits, r_Last_Grant and the fixed-priority macro; outputs grant valid and grant index.
- Watchdog counter and FSM stay in the top.

Test Plan:
- M0 write CS2 addr 0x0010 data 0xBEEF, no M1 -> one cycle o_Bus_CS_Array=4'b0100, Wr_Rd_n=1, bus carries 0x0010/0xBEEF; o_M0_Ack one cycle later; o_M1_Ack never asserts.
- M1 read CS1 addr 0x0004, peripheral asserts DV[1] 3 cycles after CS with 0x1234 -> o_M1_Rd_Data=0x1234 with o_M1_Ack, o_M1_Timeout=0.
- M0 read CS3, no DV, WD_LIMIT=8 -> o_M0_Rd_Data=0xDEAD, o_M0_Timeout=1 with Ack; Ack comes 9 cycles after the CS pulse.
- M0 and M1 both requesting continuously right after reset, 4 transactions -> grant order M0,M1,M0,M1; with LOCAL_BUS_ARB_FIXED_PRIO_EN the order is M0 every time.
- Read CS0, DV[2] asserted with junk, then DV[0] with 0x00A5 -> junk ignored, Rd_Data=0x00A5.
- i_Rst pulsed during WAIT_RD -> all outputs 0 immediately; no Ack issued; next request serviced normally, with M0 winning a tie.

Source files
------------

// File: rtl/local_bus_pkg.sv
// Shared types and constants for the local bus arbiter.
package local_bus_pkg;

  localparam int unsigned NUM_CS          = 4;
  localparam int unsigned CS_IDX_W        = $clog2(NUM_CS);
  localparam logic [15:0] RD_TIMEOUT_DATA = 16'hDEAD;
  localparam int unsigned WD_W            = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StDone
  } bus_state_e;

endpackage

// File: rtl/local_bus_rr_pick.sv
// Two-way pick between masters M0 and M1: round-robin on ties by default,
// M0 always wins ties when LOCAL_BUS_ARB_FIXED_PRIO_EN is defined.
module local_bus_rr_pick (
  input  logic i_M0_Req,
  input  logic i_M1_Req,
  input  logic i_Last_Grant,
  output logic o_Grant_Valid,
  output logic o_Grant_Idx
);

  assign o_Grant_Valid = i_M0_Req | i_M1_Req;

`ifdef LOCAL_BUS_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = i_Last_Grant;
  assign o_Grant_Idx       = ~i_M0_Req;
`else
  always_comb begin
    if (i_M0_Req && i_M1_Req) begin
      o_Grant_Idx = ~i_Last_Grant;
    end else begin
      o_Grant_Idx = i_M1_Req;
    end
  end
`endif

endmodule

// File: rtl/local_bus_arbiter.sv
// Shares the Local Bus between two command masters, one transaction at a time.
// Build option LOCAL_BUS_ARB_FIXED_PRIO_EN makes M0 win every tie.
module local_bus_arbiter
  import local_bus_pkg::*;
#(
  parameter int unsigned  ADDR8_PER_CS = 65536,
  parameter int unsigned  WD_LIMIT     = 8,
  localparam int unsigned AW           = $clog2(ADDR8_PER_CS)
) (
  input  logic              i_Bus_Clk,
  input  logic              i_Rst,
  input  logic              i_M0_Req,
  input  logic              i_M0_Wr_Rd_n,
  input  logic [1:0]        i_M0_CS_Index,
  input  logic [AW-1:0]     i_M0_Addr8,
  input  logic [15:0]       i_M0_Wr_Data,
  output logic              o_M0_Ack,
  output logic [15:0]       o_M0_Rd_Data,
  output logic              o_M0_Timeout,
  input  logic              i_M1_Req,
  input  logic              i_M1_Wr_Rd_n,
  input  logic [1:0]        i_M1_CS_Index,
  input  logic [AW-1:0]     i_M1_Addr8,
  input  logic [15:0]       i_M1_Wr_Data,
  output logic              o_M1_Ack,
  output logic [15:0]       o_M1_Rd_Data,
  output logic              o_M1_Timeout,
  output logic [NUM_CS-1:0] o_Bus_CS_Array,
  output logic              o_Bus_Wr_Rd_n,
  output logic [AW-1:0]     o_Bus_Addr8,
  output logic [15:0]       o_Bus_Wr_Data,
  input  logic [15:0]       i_Bus_Rd_Data_CS0,
  input  logic [15:0]       i_Bus_Rd_Data_CS1,
  input  logic [15:0]       i_Bus_Rd_Data_CS2,
  input  logic [15:0]       i_Bus_Rd_Data_CS3,
  input  logic [NUM_CS-1:0] i_Bus_Rd_DV_Array
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  bus_state_e          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                wr_rd_n_q, wr_rd_n_d;
  logic [CS_IDX_W-1:0] cs_idx_q, cs_idx_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         m0_rd_data_q, m0_rd_data_d;
  logic [15:0]         m1_rd_data_q, m1_rd_data_d;

  logic        grant_valid;
  logic        grant_idx;
  logic        sel_dv;
  logic [15:0] sel_rd_data;

  local_bus_rr_pick u_rr_pick (
    .i_M0_Req      (i_M0_Req),
    .i_M1_Req      (i_M1_Req),
    .i_Last_Grant  (last_grant_q),
    .o_Grant_Valid (grant_valid),
    .o_Grant_Idx   (grant_idx)
  );

  assign sel_dv = i_Bus_Rd_DV_Array[cs_idx_q];

  always_comb begin
    unique case (cs_idx_q)
      2'd0:    sel_rd_data = i_Bus_Rd_Data_CS0;
      2'd1:    sel_rd_data = i_Bus_Rd_Data_CS1;
      2'd2:    sel_rd_data = i_Bus_Rd_Data_CS2;
      default: sel_rd_data = i_Bus_Rd_Data_CS3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wr_rd_n_d    = wr_rd_n_q;
    cs_idx_d     = cs_idx_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;
    m0_rd_data_d = m0_rd_data_q;
    m1_rd_data_d = m1_rd_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          if (!grant_idx) begin
            wr_rd_n_d = i_M0_Wr_Rd_n;
            cs_idx_d  = i_M0_CS_Index;
            addr_d    = i_M0_Addr8;
            wr_data_d = i_M0_Wr_Data;
          end else begin
            wr_rd_n_d = i_M1_Wr_Rd_n;
            cs_idx_d  = i_M1_CS_Index;
            addr_d    = i_M1_Addr8;
            wr_data_d = i_M1_Wr_Data;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        timeout_d = 1'b0;
        if (wr_rd_n_q) begin
          state_d = StDone;
        end else begin
          wd_d    = '0;
          state_d = StWaitRd;
        end
      end
      StWaitRd: begin
        // A DV arriving on the expiry cycle still counts as a good read.
        if (sel_dv) begin
          if (!owner_q) m0_rd_data_d = sel_rd_data;
          else          m1_rd_data_d = sel_rd_data;
          state_d = StDone;
        end else if (wd_q == WD_LAST) begin
          if (!owner_q) m0_rd_data_d = RD_TIMEOUT_DATA;
          else          m1_rd_data_d = RD_TIMEOUT_DATA;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Bus_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wr_rd_n_q    <= 1'b0;
      cs_idx_q     <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
      m0_rd_data_q <= '0;
      m1_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wr_rd_n_q    <= wr_rd_n_d;
      cs_idx_q     <= cs_idx_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
      m0_rd_data_q <= m0_rd_data_d;
      m1_rd_data_q <= m1_rd_data_d;
    end
  end

  assign o_Bus_CS_Array = (state_q == StIssue) ? (NUM_CS'(1) << cs_idx_q) : '0;
  assign o_Bus_Wr_Rd_n  = wr_rd_n_q;
  assign o_Bus_Addr8    = addr_q;
  assign o_Bus_Wr_Data  = wr_data_q;

  assign o_M0_Ack     = (state_q == StDone) && !owner_q;
  assign o_M1_Ack     = (state_q == StDone) && owner_q;
  assign o_M0_Timeout = o_M0_Ack && timeout_q;
  assign o_M1_Timeout = o_M1_Ack && timeout_q;
  assign o_M0_Rd_Data = m0_rd_data_q;
  assign o_M1_Rd_Data = m1_rd_data_q;

endmodule

// File: tb/tb_local_bus_arbiter.sv
// Randomized bench for local_bus_arbiter against a transaction-level model
// of arbitration order, bus latencies, read capture and watchdog timeout.
module tb_local_bus_arbiter;

  localparam int unsigned ADDR8_PER_CS = 65536;
  localparam int unsigned WD_LIMIT     = 8;
  localparam int unsigned AW           = $clog2(ADDR8_PER_CS);

  logic              clk = 1'b0;
  logic              rst;
  logic              m_req  [2];
  logic              m_wr   [2];
  logic [1:0]        m_cs   [2];
  logic [AW-1:0]     m_addr [2];
  logic [15:0]       m_wd   [2];
  logic              ack0, ack1, to0, to1;
  logic [15:0]       rd0, rd1;
  logic [3:0]        bus_cs;
  logic              bus_wrn;
  logic [AW-1:0]     bus_addr;
  logic [15:0]       bus_wd;
  logic [15:0]       cs_data [4];
  logic [3:0]        dv;

  always #5 clk = ~clk;

  local_bus_arbiter #(
    .ADDR8_PER_CS (ADDR8_PER_CS),
    .WD_LIMIT     (WD_LIMIT)
  ) dut (
    .i_Bus_Clk         (clk),
    .i_Rst             (rst),
    .i_M0_Req          (m_req[0]),
    .i_M0_Wr_Rd_n      (m_wr[0]),
    .i_M0_CS_Index     (m_cs[0]),
    .i_M0_Addr8        (m_addr[0]),
    .i_M0_Wr_Data      (m_wd[0]),
    .o_M0_Ack          (ack0),
    .o_M0_Rd_Data      (rd0),
    .o_M0_Timeout      (to0),
    .i_M1_Req          (m_req[1]),
    .i_M1_Wr_Rd_n      (m_wr[1]),
    .i_M1_CS_Index     (m_cs[1]),
    .i_M1_Addr8        (m_addr[1]),
    .i_M1_Wr_Data      (m_wd[1]),
    .o_M1_Ack          (ack1),
    .o_M1_Rd_Data      (rd1),
    .o_M1_Timeout      (to1),
    .o_Bus_CS_Array    (bus_cs),
    .o_Bus_Wr_Rd_n     (bus_wrn),
    .o_Bus_Addr8       (bus_addr),
    .o_Bus_Wr_Data     (bus_wd),
    .i_Bus_Rd_Data_CS0 (cs_data[0]),
    .i_Bus_Rd_Data_CS1 (cs_data[1]),
    .i_Bus_Rd_Data_CS2 (cs_data[2]),
    .i_Bus_Rd_Data_CS3 (cs_data[3]),
    .i_Bus_Rd_DV_Array (dv)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model state
  int          n;
  int          req_pct;
  bit          arb_idle;
  bit          last_grant;
  bit          txn_live;
  bit          txn_owner;
  bit          txn_write;
  int          txn_cs_cycle;
  bit          cs_pend;
  int          cs_due;
  int          ack_due;
  bit          exp_to;
  logic [15:0] exp_rd;
  logic [15:0] rd_hold [2];
  logic [1:0]  mb_cs;
  logic        mb_wrn;
  logic [AW-1:0] mb_addr;
  logic [15:0] mb_wd;
  int          dv_at;
  int          junk_at;
  logic [1:0]  junk_cs;
  logic [15:0] junk_data;
  bit          dut_ack_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic rand_fields(input int m);
    m_wr[m]   = 1'($urandom_range(0, 1));
    m_cs[m]   = 2'($urandom_range(0, 3));
    m_addr[m] = AW'($urandom);
    m_wd[m]   = 16'($urandom);
  endtask

  task automatic model_reset();
    arb_idle   = 1'b1;
    last_grant = 1'b1;
    txn_live   = 1'b0;
    cs_pend    = 1'b0;
    dv_at      = -1;
    junk_at    = -1;
    rd_hold[0] = '0;
    rd_hold[1] = '0;
    mb_cs      = '0;
    mb_wrn     = 1'b0;
    mb_addr    = '0;
    mb_wd      = '0;
    dut_ack_q.delete();
  endtask

  // Decide a grant from the request levels just driven.
  task automatic model_grant();
    bit w;
    if (arb_idle && (m_req[0] || m_req[1])) begin
      if (m_req[0] && m_req[1]) begin
`ifdef LOCAL_BUS_ARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = !last_grant;
`endif
      end else begin
        w = m_req[1];
      end
      last_grant = w;
      txn_live   = 1'b1;
      txn_owner  = w;
      txn_write  = m_wr[w];
      mb_cs      = m_cs[w];
      mb_wrn     = m_wr[w];
      mb_addr    = m_addr[w];
      mb_wd      = m_wd[w];
      cs_pend    = 1'b1;
      cs_due     = n + 1;
      arb_idle   = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cs"}, 32'(bus_cs), 32'd0);
    check_eq({tag, "_ack"}, 32'({ack1, ack0}), 32'd0);
    check_eq({tag, "_to"}, 32'({to1, to0}), 32'd0);
    check_eq({tag, "_rd"}, {rd1, rd0}, 32'd0);
    check_eq({tag, "_bus"}, 32'({bus_wrn, bus_wd}) | 32'(bus_addr), 32'd0);
  endtask

  task automatic step();
    logic [3:0] exp_cs;
    bit         ack_now;
    int         k;
    @(negedge clk);
    n++;
    exp_cs  = '0;
    ack_now = 1'b0;
    if (cs_pend && cs_due == n) begin
      cs_pend      = 1'b0;
      exp_cs       = 4'b0001 << mb_cs;
      txn_cs_cycle = n;
      exp_to       = 1'b0;
      if (txn_write) begin
        ack_due = n + 1;
      end else begin
        k = $urandom_range(1, WD_LIMIT + 3);
        if (k > WD_LIMIT) begin
          dv_at   = -1;
          ack_due = n + WD_LIMIT + 1;
          exp_rd  = 16'hDEAD;
          exp_to  = 1'b1;
          k       = WD_LIMIT;
        end else begin
          dv_at   = n + k;
          ack_due = n + k + 1;
          exp_rd  = 16'($urandom);
        end
        if ($urandom_range(0, 1) == 1) begin
          junk_at   = n + $urandom_range(1, k);
          junk_cs   = mb_cs + 2'($urandom_range(1, 3));
          junk_data = 16'($urandom);
        end
      end
    end
    if (txn_live && !cs_pend && ack_due == n) begin
      ack_now = 1'b1;
      if (!txn_write) rd_hold[txn_owner] = exp_rd;
    end
    if (ack0) dut_ack_q.push_back(1'b0);
    if (ack1) dut_ack_q.push_back(1'b1);

    check_eq("cs_array", 32'(bus_cs), 32'(exp_cs));
    check_eq("m0_ack", 32'(ack0), 32'(ack_now && !txn_owner));
    check_eq("m1_ack", 32'(ack1), 32'(ack_now && txn_owner));
    check_eq("m0_timeout", 32'(to0), 32'(ack_now && !txn_owner && !txn_write && exp_to));
    check_eq("m1_timeout", 32'(to1), 32'(ack_now && txn_owner && !txn_write && exp_to));
    check_eq("m0_rd_data", 32'(rd0), 32'(rd_hold[0]));
    check_eq("m1_rd_data", 32'(rd1), 32'(rd_hold[1]));
    check_eq("bus_wr_rd_n", 32'(bus_wrn), 32'(mb_wrn));
    check_eq("bus_addr", 32'(bus_addr), 32'(mb_addr));
    check_eq("bus_wr_data", 32'(bus_wd), 32'(mb_wd));

    dv = '0;
    for (int i = 0; i < 4; i++) cs_data[i] = 16'($urandom);
    if (dv_at == n) begin
      dv[mb_cs]      = 1'b1;
      cs_data[mb_cs] = exp_rd;
    end
    if (junk_at == n) begin
      dv[junk_cs]      = 1'b1;
      cs_data[junk_cs] = junk_data;
    end
    for (int m = 0; m < 2; m++) begin
      if (ack_now && txn_owner == m[0]) begin
        m_req[m] = 1'b0;
      end else if (!m_req[m]) begin
        rand_fields(m);
        if ($urandom_range(0, 99) < req_pct) m_req[m] = 1'b1;
      end
    end
    model_grant();
    if (ack_now) begin
      arb_idle = 1'b1;
      txn_live = 1'b0;
      dv_at    = -1;
      junk_at  = -1;
    end
  endtask

  // Release reset on a negedge and have both masters request together.
  task automatic release_with_tie();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      rand_fields(m);
      m_req[m] = 1'b1;
    end
    model_grant();
  endtask

  initial begin
    int guard;
    bit exp_order [4];
    n   = 0;
    rst = 1'b1;
    dv  = '0;
    for (int i = 0; i < 4; i++) cs_data[i] = '0;
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 1'b0;
      rand_fields(m);
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Continuous contention straight out of reset
    req_pct = 100;
    release_with_tie();
    guard = 0;
    while (dut_ack_q.size() < 4 && guard < 200) begin
      step();
      guard++;
    end
    check_eq("order_count", 32'(dut_ack_q.size() >= 4), 32'd1);
`ifdef LOCAL_BUS_ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < dut_ack_q.size()) check_eq("grant_order", 32'(dut_ack_q[i]), 32'(exp_order[i]));
    end

    // Random traffic
    req_pct = 40;
    repeat (1500) step();

    // Reset while a read is waiting for DV
    guard = 0;
    while (!(txn_live && !cs_pend && !txn_write && n > txn_cs_cycle && n + 1 < ack_due)
           && guard < 3000) begin
      step();
      guard++;
    end
    check_eq("reach_wait_rd", 32'(guard < 3000), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    dv       = '0;
    @(negedge clk);
    n++;
    check_all_zero("held_reset");
    release_with_tie();
    guard = 0;
    while (dut_ack_q.size() < 1 && guard < 100) begin
      step();
      guard++;
    end
    check_eq("post_reset_ack", 32'(dut_ack_q.size() >= 1), 32'd1);
    if (dut_ack_q.size() >= 1) check_eq("post_reset_tie", 32'(dut_ack_q[0]), 32'd0);
    repeat (300) step();

    // Drain
    req_pct = 0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
